// File: rtl/iu_pkg.sv
// Issue-unit shared definitions: bundle layout and packer.
// Used by the issue unit and the IBuffer-side packer.
package iu_pkg;

  localparam int BUNDLE_W  = 78;

  localparam int SCB_LSB   = 0;
  localparam int SCB_W     = 2;
  localparam int BLT_BIT   = 2;
  localparam int BEQ_BIT   = 3;
  localparam int SHGB_BIT  = 4;
  localparam int MEMRD_BIT = 5;
  localparam int MEMWR_BIT = 6;
  localparam int REGWR_BIT = 7;
  localparam int ALUOP_LSB = 8;
  localparam int ALUOP_W   = 4;
  localparam int IMME_LSB  = 12;
  localparam int IMME_W    = 16;
  localparam int REG_W     = 6;
  localparam int DST_LSB   = 28;
  localparam int SRC2_LSB  = 34;
  localparam int SRC1_LSB  = 40;
  localparam int INSTR_LSB = 46;
  localparam int INSTR_W   = 32;

  typedef logic [BUNDLE_W-1:0] bundle_t;

  function automatic bundle_t pack_bundle(
    input logic [INSTR_W-1:0] instr,
    input logic [REG_W-1:0]   src1,
    input logic [REG_W-1:0]   src2,
    input logic [REG_W-1:0]   dst,
    input logic [IMME_W-1:0]  imme,
    input logic [ALUOP_W-1:0] aluop,
    input logic [5:0]         flags,
    input logic [SCB_W-1:0]   scb_id
  );
    // flags: {RegWrite,MemWrite,MemRead,Shared_Globalbar,BEQ,BLT}
    return {instr, src1, src2, dst, imme, aluop, flags, scb_id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Double-width masked priority encoder starting at ptr.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({2*N{1'b1}} << ptr);
    any     = 1'b0;
    gnt_idx = '0;
    // downward scan leaves the lowest set bit
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        any     = 1'b1;
        gnt_idx = PW'(i % N);
      end
    end
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/issue_unit.sv
// Issue stage: RR issue arbitration into a one-entry OC
// output register, plus exit arbitration and exited tracking.
module issue_unit
  import iu_pkg::*;
#(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WARPS-1:0]          Req_IB_IU,
  output logic [NUM_WARPS-1:0]          Grt_IU_IB,
  input  logic [NUM_WARPS*BUNDLE_W-1:0] Bundle_IB_IU,
  input  logic [NUM_WARPS-1:0]          Exit_Req_IB_IU,
  output logic [NUM_WARPS-1:0]          Exit_Grt_IU_IB,
  output logic                          Valid_IU_OC,
  input  logic                          Ready_OC_IU,
  output logic [WID_W-1:0]              WarpID_IU_OC,
  output logic [BUNDLE_W-1:0]           Bundle_IU_OC,
  input  logic                          Launch_RAU_IU,
  output logic [NUM_WARPS-1:0]          Exited_IU_RAU,
  output logic                          AllDone_IU_RAU
);

  logic                 issue_en;
  logic [NUM_WARPS-1:0] iss_req;
  logic [NUM_WARPS-1:0] ext_req;
  logic [WID_W-1:0]     iss_ptr;
  logic [WID_W-1:0]     ext_ptr;
  logic [WID_W-1:0]     iss_idx;
  logic [WID_W-1:0]     ext_idx;
  logic                 iss_any;
  logic                 ext_any;
  logic [NUM_WARPS-1:0] exited_next;
  bundle_t              sel_bundle;

  assign issue_en = !Valid_IU_OC || Ready_OC_IU;

  // grants forced low while reset is held
  assign iss_req = (issue_en && !rst)
                 ? (Req_IB_IU & ~Exited_IU_RAU)
                 : '0;
  assign ext_req = rst
                 ? '0
                 : (Exit_Req_IB_IU & ~Exited_IU_RAU);

  rr_arbiter #(.N(NUM_WARPS)) u_iss_arb (
    .req     (iss_req),
    .ptr     (iss_ptr),
    .gnt     (Grt_IU_IB),
    .gnt_idx (iss_idx),
    .any     (iss_any)
  );

  rr_arbiter #(.N(NUM_WARPS)) u_ext_arb (
    .req     (ext_req),
    .ptr     (ext_ptr),
    .gnt     (Exit_Grt_IU_IB),
    .gnt_idx (ext_idx),
    .any     (ext_any)
  );

  assign sel_bundle =
    Bundle_IB_IU[iss_idx*BUNDLE_W +: BUNDLE_W];

  // launch beats a simultaneous exit
  always_comb begin
    exited_next = Exited_IU_RAU;
    if (Launch_RAU_IU)
      exited_next = '0;
    else if (ext_any)
      exited_next = Exited_IU_RAU | Exit_Grt_IU_IB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Valid_IU_OC  <= 1'b0;
      WarpID_IU_OC <= '0;
      Bundle_IU_OC <= '0;
      iss_ptr      <= '0;
    end else if (iss_any) begin
      Valid_IU_OC  <= 1'b1;
      WarpID_IU_OC <= iss_idx;
      Bundle_IU_OC <= sel_bundle;
      iss_ptr      <= iss_idx + WID_W'(1);
    end else if (Ready_OC_IU) begin
      Valid_IU_OC  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Exited_IU_RAU  <= '0;
      AllDone_IU_RAU <= 1'b0;
      ext_ptr        <= '0;
    end else begin
      Exited_IU_RAU  <= exited_next;
      AllDone_IU_RAU <= &exited_next;
      if (ext_any)
        ext_ptr <= ext_idx + WID_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed table,
// hand sequences and random traffic against a reference model.
module tb_issue_unit;

  localparam int N  = 8;
  localparam int BW = 78;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    grt;
  logic [N*BW-1:0] bun_in;
  logic [N-1:0]    ext;
  logic [N-1:0]    egrt;
  logic            valid;
  logic            ready;
  logic [2:0]      wid;
  logic [BW-1:0]   bun_out;
  logic            launch;
  logic [N-1:0]    exited;
  logic            done;

  issue_unit #(.NUM_WARPS(N), .WID_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .Req_IB_IU      (req),
    .Grt_IU_IB      (grt),
    .Bundle_IB_IU   (bun_in),
    .Exit_Req_IB_IU (ext),
    .Exit_Grt_IU_IB (egrt),
    .Valid_IU_OC    (valid),
    .Ready_OC_IU    (ready),
    .WarpID_IU_OC   (wid),
    .Bundle_IU_OC   (bun_out),
    .Launch_RAU_IU  (launch),
    .Exited_IU_RAU  (exited),
    .AllDone_IU_RAU (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [BW-1:0] act,
                     logic [BW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // reference model state
  bit            m_valid;
  int            m_wid;
  logic [BW-1:0] m_bun;
  bit [N-1:0]    m_exited;
  int            m_iss_ptr;
  int            m_ext_ptr;

  function automatic void model_reset();
    m_valid   = 0;
    m_wid     = 0;
    m_bun     = '0;
    m_exited  = '0;
    m_iss_ptr = 0;
    m_ext_ptr = 0;
  endfunction

  function automatic int pick(bit [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // called at a negedge with inputs already driven
  task automatic tick();
    int gi;
    int ei;
    bit en;
    #1;
    en = !m_valid || ready;
    gi = en ? pick(req & ~m_exited, m_iss_ptr) : -1;
    ei = pick(ext & ~m_exited, m_ext_ptr);
    chk("grt", BW'(grt), BW'(onehot(gi)));
    chk("exit_grt", BW'(egrt), BW'(onehot(ei)));
    chk("valid", BW'(valid), BW'(m_valid));
    chk("warp_id", BW'(wid), BW'(m_wid));
    chk("bundle", bun_out, m_bun);
    chk("exited", BW'(exited), BW'(m_exited));
    chk("all_done", BW'(done), BW'(&m_exited));
    @(posedge clk);
    if (gi >= 0) begin
      m_valid   = 1;
      m_wid     = gi;
      m_bun     = bun_in[gi*BW +: BW];
      m_iss_ptr = (gi + 1) % N;
    end else if (ready) begin
      m_valid = 0;
    end
    if (ei >= 0) m_ext_ptr = (ei + 1) % N;
    if (launch) m_exited = '0;
    else if (ei >= 0) m_exited[ei] = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_bundles();
    for (int w = 0; w < N; w++)
      bun_in[w*BW +: BW] = BW'({$urandom, $urandom, $urandom});
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] ext;
    logic         rdy;
    logic         launch;
    logic [N-1:0] grt;
    logic [N-1:0] egrt;
    logic [N-1:0] exited;
    logic         done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [N-1:0] r, logic [N-1:0] e,
                              logic rd, logic l, logic [N-1:0] g,
                              logic [N-1:0] eg, logic [N-1:0] x,
                              logic d);
    vec_t v;
    v.req = r; v.ext = e; v.rdy = rd; v.launch = l;
    v.grt = g; v.egrt = eg; v.exited = x; v.done = d;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] g;

    // full-request rotation
    g = 8'h01;
    for (int i = 0; i < 9; i++) begin
      add(8'hFF, 0, 1, 0, g, 0, 0, 0);
      g = {g[N-2:0], g[N-1]};
    end
    // pointer at 1 then 3: two-warp fairness
    add(8'h04, 0, 1, 0, 8'h04, 0, 0, 0);
    add(8'h24, 0, 1, 0, 8'h20, 0, 0, 0);
    add(8'h24, 0, 1, 0, 8'h04, 0, 0, 0);
    add(8'h24, 0, 1, 0, 8'h20, 0, 0, 0);
    // exits of warps 0 and 7
    add(8'h00, 8'h81, 1, 0, 0, 8'h01, 8'h00, 0);
    add(8'h00, 8'h81, 1, 0, 0, 8'h80, 8'h01, 0);
    add(8'h81, 8'h00, 1, 0, 0, 0, 8'h81, 0);
    add(8'hFF, 8'h00, 1, 0, 8'h40, 0, 8'h81, 0);
    // remaining warps exit one by one
    add(0, 8'h7E, 1, 0, 0, 8'h02, 8'h81, 0);
    add(0, 8'h7E, 1, 0, 0, 8'h04, 8'h83, 0);
    add(0, 8'h7E, 1, 0, 0, 8'h08, 8'h87, 0);
    add(0, 8'h7E, 1, 0, 0, 8'h10, 8'h8F, 0);
    add(0, 8'h7E, 1, 0, 0, 8'h20, 8'h9F, 0);
    add(0, 8'h7E, 1, 0, 0, 8'h40, 8'hBF, 0);
    add(0, 8'h00, 1, 1, 0, 0, 8'hFF, 1);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);

    rst = 1'b1;
    req = 8'hFF;
    ext = 8'hFF;
    ready = 1'b1;
    launch = 1'b0;
    rand_bundles();
    model_reset();

    #2;
    chk("rst_grt", BW'(grt), 0);
    chk("rst_exit_grt", BW'(egrt), 0);
    chk("rst_valid", BW'(valid), 0);
    chk("rst_bundle", bun_out, 0);
    chk("rst_done", BW'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req    = tbl[i].req;
      ext    = tbl[i].ext;
      ready  = tbl[i].rdy;
      launch = tbl[i].launch;
      rand_bundles();
      #1;
      chk($sformatf("tbl%0d_grt", i), BW'(grt), BW'(tbl[i].grt));
      chk($sformatf("tbl%0d_egrt", i), BW'(egrt), BW'(tbl[i].egrt));
      chk($sformatf("tbl%0d_exited", i), BW'(exited),
          BW'(tbl[i].exited));
      chk($sformatf("tbl%0d_done", i), BW'(done), BW'(tbl[i].done));
      tick();
    end

    // stall: ptr is 7, so warp 7 issues, then held 3 cycles
    req = 8'hFF; ext = 0; launch = 0; ready = 1;
    rand_bundles();
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bundles();
      tick();
    end
    ready = 1'b1;
    #1;
    chk("stall_wid", BW'(wid), 7);
    chk("resume_grt", BW'(grt), BW'(8'h01));
    tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req    = N'($urandom);
      ext    = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      ready  = ($urandom_range(0, 3) != 0);
      launch = ($urandom_range(0, 15) == 0);
      rand_bundles();
      tick();
    end

    // async reset while holding a valid instruction
    req = 8'hFF; ext = 0; launch = 0; ready = 1;
    tick();
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", BW'(valid), 0);
    chk("arst_grt", BW'(grt), 0);
    chk("arst_wid", BW'(wid), 0);
    chk("arst_bundle", bun_out, 0);
    chk("arst_exited", BW'(exited), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    #1;
    chk("post_rst_grt", BW'(grt), BW'(8'h01));
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
